// File: rtl/bpuf_pkg.sv
// bpuf_pkg: shared types and helpers for the butterfly-PUF challenge/response
// control slice.
//   crp_state_t  - sequencer state encoding
//   BPUF_CHAL_W  - default PUF challenge width
//   BPUF_RESP_W  - default PUF response width
//   BPUF_POP_W   - widest vector popcount() accepts
//   popcount()   - number of set bits in a vector of up to BPUF_POP_W bits
package bpuf_pkg;

   localparam int BPUF_CHAL_W = 19;
   localparam int BPUF_RESP_W = 19;
   localparam int BPUF_POP_W  = 32;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      APPLY   = 3'd1,
      SETTLE  = 3'd2,
      CAPTURE = 3'd3,
      COMPARE = 3'd4,
      DONE    = 3'd5
   } crp_state_t;

   function automatic int unsigned popcount(input logic [BPUF_POP_W-1:0] v);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < BPUF_POP_W; i++) begin
         n += 32'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/bpuf_hd_calc.sv
// bpuf_hd_calc: combinational Hamming distance between a captured response and
// the enrolled golden response, plus the threshold compare.
// Ports:
//   resp      in  RESP_W : captured PUF response
//   golden    in  RESP_W : enrolled golden response
//   threshold in  HD_W   : largest distance still counted as a match
//   hd        out HD_W   : popcount(resp ^ golden)
//   match     out 1      : hd <= threshold
module bpuf_hd_calc
   import bpuf_pkg::*;
#(
   parameter int RESP_W = BPUF_RESP_W,
   parameter int HD_W   = 5
) (
   input  logic [RESP_W-1:0] resp,
   input  logic [RESP_W-1:0] golden,
   input  logic [HD_W-1:0]   threshold,
   output logic [HD_W-1:0]   hd,
   output logic              match
);

   logic [BPUF_POP_W-1:0] diff;

   always_comb begin
      diff             = '0;
      diff[RESP_W-1:0] = resp ^ golden;
      // Distance never exceeds RESP_W, which fits in HD_W bits.
      hd               = HD_W'(popcount(diff));
      match            = (hd <= threshold);
   end

endmodule

// File: rtl/bpuf_crp_ctrl.sv
// bpuf_crp_ctrl: challenge/response sequencer for the butterfly-PUF core.
// Latches challenge, golden response and mode, applies the challenge, waits
// SETTLE_CYC cycles, captures the response, then reports response, Hamming
// distance to golden and a threshold match flag with a one-cycle done pulse.
// Optional build macro: BPUF_CRP_MAJORITY_EN - capture three consecutive
// samples and keep the bitwise 2-of-3 majority (adds two cycles of latency).
// Ports:
//   clk, reset_n (async, active low)
//   start, chal_in, golden_in, user_in : request and its operands (IDLE only)
//   threshold                          : max HD counted as match
//   puf_chal, puf_enable, puf_user     : drive to PUF core
//   puf_resp                           : PUF core response
//   busy, done, resp_out, hd_out, match: status and held results
module bpuf_crp_ctrl
   import bpuf_pkg::*;
#(
   parameter int CHAL_W     = BPUF_CHAL_W,
   parameter int RESP_W     = BPUF_RESP_W,
   parameter int SETTLE_CYC = 8,
   parameter int HD_W       = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [CHAL_W-1:0] chal_in,
   input  logic [RESP_W-1:0] golden_in,
   input  logic [1:0]        user_in,
   input  logic [HD_W-1:0]   threshold,
   output logic [CHAL_W-1:0] puf_chal,
   output logic              puf_enable,
   output logic [1:0]        puf_user,
   input  logic [RESP_W-1:0] puf_resp,
   output logic              busy,
   output logic              done,
   output logic [RESP_W-1:0] resp_out,
   output logic [HD_W-1:0]   hd_out,
   output logic              match
);

   if (SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_bad_settle
      $error("bpuf_crp_ctrl: SETTLE_CYC must be in 1..255");
   end
   if ((1 << HD_W) <= RESP_W) begin : g_bad_hd_w
      $error("bpuf_crp_ctrl: HD_W too narrow for RESP_W");
   end
   if (RESP_W > BPUF_POP_W) begin : g_bad_resp_w
      $error("bpuf_crp_ctrl: RESP_W exceeds popcount width");
   end

   crp_state_t        state;
   logic [7:0]        cnt;
   logic [RESP_W-1:0] golden_q;
   logic [HD_W-1:0]   hd_c;
   logic              match_c;

`ifdef BPUF_CRP_MAJORITY_EN
   logic [1:0]        cap_cnt;
   logic [RESP_W-1:0] samp0;
   logic [RESP_W-1:0] samp1;
`endif

   bpuf_hd_calc #(
      .RESP_W (RESP_W),
      .HD_W   (HD_W)
   ) u_hd (
      .resp      (resp_out),
      .golden    (golden_q),
      .threshold (threshold),
      .hd        (hd_c),
      .match     (match_c)
   );

   // puf_chal/puf_user double as the latched challenge and mode registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         golden_q   <= '0;
         puf_chal   <= '0;
         puf_user   <= '0;
         puf_enable <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         resp_out   <= '0;
         hd_out     <= '0;
         match      <= 1'b0;
`ifdef BPUF_CRP_MAJORITY_EN
         cap_cnt    <= '0;
         samp0      <= '0;
         samp1      <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  puf_chal   <= chal_in;
                  golden_q   <= golden_in;
                  puf_user   <= user_in;
                  puf_enable <= 1'b1;
                  busy       <= 1'b1;
                  state      <= APPLY;
               end
            end
            APPLY: begin
               cnt   <= 8'(SETTLE_CYC - 1);
               state <= SETTLE;
            end
            SETTLE: begin
               if (cnt == '0) begin
                  state <= CAPTURE;
`ifdef BPUF_CRP_MAJORITY_EN
                  cap_cnt <= '0;
`endif
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            CAPTURE: begin
`ifdef BPUF_CRP_MAJORITY_EN
               case (cap_cnt)
                  2'd0: begin
                     samp0   <= puf_resp;
                     cap_cnt <= 2'd1;
                  end
                  2'd1: begin
                     samp1   <= puf_resp;
                     cap_cnt <= 2'd2;
                  end
                  default: begin
                     // Third sample is used live rather than stored.
                     resp_out   <= (samp0 & samp1) | (samp0 & puf_resp) |
                                   (samp1 & puf_resp);
                     puf_enable <= 1'b0;
                     state      <= COMPARE;
                  end
               endcase
`else
               resp_out   <= puf_resp;
               puf_enable <= 1'b0;
               state      <= COMPARE;
`endif
            end
            COMPARE: begin
               hd_out <= hd_c;
               match  <= match_c;
               done   <= 1'b1;
               state  <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy       <= 1'b0;
               puf_enable <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bpuf_crp_ctrl.sv
// tb_bpuf_crp_ctrl: directed-vector bench for bpuf_crp_ctrl with SETTLE_CYC=8.
// Inputs change on falling edges; outputs are sampled on falling edges.
// Cycle i of a run is the cycle following the i-th rising edge after start
// was sampled; done is expected in cycle LAT.
module tb_bpuf_crp_ctrl;

   localparam int SC = 8;
`ifdef BPUF_CRP_MAJORITY_EN
   localparam int LAT = SC + 6;
`else
   localparam int LAT = SC + 4;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [18:0] chal_in;
   logic [18:0] golden_in;
   logic [1:0]  user_in;
   logic [4:0]  threshold;
   logic [18:0] puf_chal;
   logic        puf_enable;
   logic [1:0]  puf_user;
   logic [18:0] puf_resp;
   logic        busy;
   logic        done;
   logic [18:0] resp_out;
   logic [4:0]  hd_out;
   logic        match;

   int nvec = 0;
   int nmis = 0;
   int maj_test = 0;

   always #5 clk = ~clk;

   bpuf_crp_ctrl #(
      .CHAL_W     (19),
      .RESP_W     (19),
      .SETTLE_CYC (SC),
      .HD_W       (5)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .chal_in    (chal_in),
      .golden_in  (golden_in),
      .user_in    (user_in),
      .threshold  (threshold),
      .puf_chal   (puf_chal),
      .puf_enable (puf_enable),
      .puf_user   (puf_user),
      .puf_resp   (puf_resp),
      .busy       (busy),
      .done       (done),
      .resp_out   (resp_out),
      .hd_out     (hd_out),
      .match      (match)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One request; returns the cycle done appeared in (0 if never).
   // inj > 0 pulses a second start with different operands in cycle inj.
   task automatic run(input logic [18:0] c, input logic [18:0] g,
                      input logic [18:0] r, input logic [1:0] u,
                      input logic [4:0] thr, input int inj,
                      input logic [18:0] exp_r, output int lat);
      @(negedge clk);
      chal_in   = c;
      golden_in = g;
      user_in   = u;
      puf_resp  = r;
      threshold = thr;
      start     = 1'b1;
      lat       = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) begin
            start = 1'b0;
            chk("apply_enable", 32'(puf_enable), 32'd1);
            chk("apply_chal", 32'(puf_chal), 32'(c));
            chk("apply_user", 32'(puf_user), 32'(u));
            chk("apply_busy", 32'(busy), 32'd1);
         end
         if (inj > 0 && i == inj) begin
            start     = 1'b1;
            chal_in   = ~c;
            golden_in = ~g;
            user_in   = ~u;
         end
         if (inj > 0 && i == inj + 1) start = 1'b0;
         if (maj_test != 0 && i == SC + 3) puf_resp = 19'h00000;
         if (maj_test != 0 && i == SC + 4) puf_resp = 19'h00001;
         if (i == LAT - 1) chk("resp_valid_early", 32'(resp_out), 32'(exp_r));
         if (done) begin
            lat = i;
            break;
         end
      end
      chk("done_seen", 32'(lat != 0), 32'd1);
      chk("latency", 32'(lat), 32'(LAT));
      chk("enable_dropped", 32'(puf_enable), 32'd0);
      chk("chal_held", 32'(puf_chal), 32'(c));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_resp"}, 32'(resp_out), 32'd0);
      chk({tag, "_hd"}, 32'(hd_out), 32'd0);
      chk({tag, "_match"}, 32'(match), 32'd0);
      chk({tag, "_enable"}, 32'(puf_enable), 32'd0);
      chk({tag, "_chal"}, 32'(puf_chal), 32'd0);
      chk({tag, "_user"}, 32'(puf_user), 32'd0);
   endtask

   initial begin
      int lat;
      int ndone;
      int d1;
      int d2;
      int blow;

      reset_n   = 1'b0;
      start     = 1'b0;
      chal_in   = '0;
      golden_in = '0;
      user_in   = '0;
      threshold = '0;
      puf_resp  = '0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic run, threshold 2 then 1.
      run(19'h12345, 19'h0F0F0, 19'h0F0F3, 2'b10, 5'd2, 0, 19'h0F0F3, lat);
      chk("basic_resp", 32'(resp_out), 32'h0F0F3);
      chk("basic_hd", 32'(hd_out), 32'd2);
      chk("basic_match_t2", 32'(match), 32'd1);
      chk("basic_busy_in_done", 32'(busy), 32'd1);
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("resp_held", 32'(resp_out), 32'h0F0F3);

      run(19'h12345, 19'h0F0F0, 19'h0F0F3, 2'b01, 5'd1, 0, 19'h0F0F3, lat);
      chk("basic_match_t1", 32'(match), 32'd0);
      chk("basic_hd_t1", 32'(hd_out), 32'd2);

      // Boundaries.
      run(19'h00001, 19'h7FFFF, 19'h7FFFF, 2'b00, 5'd0, 0, 19'h7FFFF, lat);
      chk("equal_hd", 32'(hd_out), 32'd0);
      chk("equal_match_t0", 32'(match), 32'd1);

      run(19'h00002, 19'h2AAAA, 19'h55555, 2'b11, 5'd18, 0, 19'h55555, lat);
      chk("inv_hd", 32'(hd_out), 32'd19);
      chk("inv_match_t18", 32'(match), 32'd0);
      run(19'h00003, 19'h2AAAA, 19'h55555, 2'b11, 5'd19, 0, 19'h55555, lat);
      chk("inv_match_t19", 32'(match), 32'd1);
      run(19'h00004, 19'h2AAAA, 19'h55555, 2'b11, 5'd31, 0, 19'h55555, lat);
      chk("inv_match_t31", 32'(match), 32'd1);

      // Busy rejection: second start at cycle 5 with other operands.
      run(19'h12345, 19'h0F0F0, 19'h0F0F3, 2'b10, 5'd2, 5, 19'h0F0F3, lat);
      chk("busy_resp", 32'(resp_out), 32'h0F0F3);
      chk("busy_hd", 32'(hd_out), 32'd2);
      chk("busy_user", 32'(puf_user), 32'd2);
      ndone = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("busy_extra_done", 32'(ndone), 32'd0);
      chk("busy_chal", 32'(puf_chal), 32'h12345);

      // Reset in the middle of SETTLE.
      @(negedge clk);
      chal_in   = 19'h0ABCD;
      golden_in = 19'h00000;
      puf_resp  = 19'h00F00;
      start     = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
      end
      reset_n = 1'b0;
      #1;
      check_zero("midreset");
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("midreset_no_done", 32'(ndone), 32'd0);
      run(19'h0ABCD, 19'h00000, 19'h00F00, 2'b01, 5'd4, 0, 19'h00F00, lat);
      chk("post_reset_hd", 32'(hd_out), 32'd4);
      chk("post_reset_match", 32'(match), 32'd1);

      // Back-to-back with start held high.
      @(negedge clk);
      chal_in   = 19'h11111;
      golden_in = 19'h11111;
      puf_resp  = 19'h11111;
      threshold = 5'd0;
      start     = 1'b1;
      d1 = 0;
      d2 = 0;
      blow = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (d1 != 0 && !busy) blow++;
         if (done) begin
            if (d1 == 0) d1 = i;
            else begin
               d2 = i;
               start = 1'b0;
               break;
            end
         end
      end
      chk("b2b_first_done", 32'(d1), 32'(LAT));
      chk("b2b_period", 32'(d2 - d1), 32'(LAT + 1));
      chk("b2b_busy_gap", 32'(blow), 32'd1);
      repeat (3) @(negedge clk);
      chk("b2b_stopped", 32'(busy), 32'd0);

`ifdef BPUF_CRP_MAJORITY_EN
      maj_test = 1;
      run(19'h00055, 19'h00000, 19'h00001, 2'b00, 5'd1, 0, 19'h00001, lat);
      maj_test = 0;
      chk("maj_resp", 32'(resp_out), 32'h00001);
      chk("maj_hd", 32'(hd_out), 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
